// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access path: access types used by the
// decoder / EX-MEM register, and the MEM-stage access FSM states.
package dmem_pkg;

  typedef enum logic [1:0] {
    DT_WORD  = 2'b00,
    DT_HALF  = 2'b01,
    DT_BYTE  = 2'b10,
    DT_BYTEU = 2'b11
  } dmem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } dmem_state_e;

  // Bytes are always aligned; stores use the same rule as loads.
  function automatic logic is_misaligned(dmem_type_e t, logic [1:0] off);
    return ((t == DT_WORD) && (off != 2'b00)) || ((t == DT_HALF) && off[0]);
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Request/grant/response data bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [3:0]        bus_be_o;
  logic [31:0]       bus_wdata_o;
  logic              bus_gnt_i;
  logic              bus_rvalid_i;
  logic [31:0]       bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables / replicated data, and load
// lane extraction with sign or zero extension. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  dmem_type_e  st_type_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  dmem_type_e  ld_type_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);
  logic [31:0] lane;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_type_i)
      DT_HALF: begin
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      DT_BYTE, DT_BYTEU: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      default: ;
    endcase
  end

  assign lane = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = lane;
    case (ld_type_i)
      DT_HALF:  ld_data_o = {{16{lane[15]}}, lane[15:0]};
      DT_BYTE:  ld_data_o = {{24{lane[7]}}, lane[7:0]};
      DT_BYTEU: ld_data_o = {24'h0, lane[7:0]};
      default:  ;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: runs one bus access per instruction,
// stalls the pipeline until it completes and returns extended load data.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              dmem_ena_i,
  input  logic              dmem_wena_i,
  input  logic [1:0]        dmem_type_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              load_valid_o,
  output logic              misalign_o,
  dmem_access_unit_if.master bus
);
  dmem_state_e state;
  dmem_type_e  in_type, type_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic        in_mis;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign in_type = dmem_type_e'(dmem_type_i);
  assign in_mis  = is_misaligned(in_type, addr_i[1:0]);

  dmem_lane_align u_align (
    .st_type_i  (in_type),
    .st_off_i   (addr_i[1:0]),
    .st_wdata_i (wdata_i),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_type_i  (type_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (bus.bus_rdata_i),
    .ld_data_o  (ld_data)
  );

  // DONE releases the stall; the instruction still sitting in MEM there is
  // the one just completed, so it must not re-arm an access.
  assign stall_o = rst_n_i &
                   (((state == ST_IDLE) && dmem_ena_i && !in_mis) ||
                    (state == ST_REQ) || (state == ST_RESP));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= ST_IDLE;
      type_q          <= DT_WORD;
      off_q           <= 2'b00;
      we_q            <= 1'b0;
      bus.bus_req_o   <= 1'b0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= '0;
      bus.bus_be_o    <= 4'b0000;
      bus.bus_wdata_o <= 32'h0;
      load_data_o     <= '0;
      load_valid_o    <= 1'b0;
      misalign_o      <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dmem_ena_i && in_mis) begin
            misalign_o <= 1'b1;
          end else if (dmem_ena_i) begin
            type_q          <= in_type;
            off_q           <= addr_i[1:0];
            we_q            <= dmem_wena_i;
            bus.bus_req_o   <= 1'b1;
            bus.bus_we_o    <= dmem_wena_i;
            bus.bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            bus.bus_be_o    <= st_be;
            bus.bus_wdata_o <= st_wdata;
            state           <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.bus_gnt_i) begin
            bus.bus_req_o <= 1'b0;
            state         <= we_q ? ST_DONE : ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.bus_rvalid_i) begin
            load_data_o  <= ld_data;
            load_valid_o <= 1'b1;
            state        <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed + randomized bench for dmem_access_unit with a responsive bus model
// and a spec-level reference for lanes, extension and stall length.
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, wena;
  logic [1:0]  dtype;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, misalign;
  logic [31:0] load_data;
  logic [31:0] last_ld;
  int          total = 0;
  int          bad   = 0;

  dmem_access_unit_if #(.ADDR_W(32)) bus_if ();

  dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .dmem_ena_i   (ena),
    .dmem_wena_i  (wena),
    .dmem_type_i  (dtype),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .stall_o      (stall),
    .load_data_o  (load_data),
    .load_valid_o (load_valid),
    .misalign_o   (misalign),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [1:0] t, logic [1:0] off, logic [31:0] rd);
    logic [31:0] lane;
    int v;
    lane = rd >> (8 * off);
    case (t)
      2'd0:    v = lane;
      2'd1:    v = int'($signed(lane[15:0]));
      2'd2:    v = int'($signed(lane[7:0]));
      default: v = int'(lane[7:0]);
    endcase
    return v;
  endfunction

  function automatic logic [3:0] ref_be(logic [1:0] t, logic [1:0] off);
    if (t == 2'd0) return 4'hF;
    if (t == 2'd1) return 4'(3 << off);
    return 4'(1 << off);
  endfunction

  function automatic logic [31:0] ref_wd(logic [1:0] t, logic [31:0] wd);
    if (t == 2'd0) return wd;
    if (t == 2'd1) return {wd[15:0], wd[15:0]};
    return wd[7:0] * 32'h0101_0101;
  endfunction

  task automatic access(string tag, bit we, logic [1:0] t, logic [31:0] a,
                        logic [31:0] wd, int gd, int rd, logic [31:0] rdata);
    bit mis;
    bit done;
    int stalls, req_seen, since_gnt;
    mis = ((t == 2'd0) && (a[1:0] != 2'b00)) || ((t == 2'd1) && a[0]);
    done = 1'b0; stalls = 1; req_seen = 0; since_gnt = -1;
    @(negedge clk);
    ena = 1'b1; wena = we; dtype = t; addr = a; wdata = wd;
    bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0; bus_if.bus_rdata_i = rdata;
    #1;
    if (mis) begin
      chk({tag, "_mis_stall"}, stall, 0);
      @(negedge clk); ena = 1'b0; #1;
      chk({tag, "_mis_pulse"}, misalign, 1);
      chk({tag, "_mis_req"}, bus_if.bus_req_o, 0);
      @(negedge clk); #1;
      chk({tag, "_mis_end"}, misalign, 0);
      chk({tag, "_mis_req2"}, bus_if.bus_req_o, 0);
      return;
    end
    chk({tag, "_idle_stall"}, stall, 1);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0;
      if (since_gnt >= 0) since_gnt++;
      if (bus_if.bus_req_o) begin
        if (req_seen == 0) begin
          chk({tag, "_addr"}, bus_if.bus_addr_o, {a[31:2], 2'b00});
          chk({tag, "_be"}, bus_if.bus_be_o, ref_be(t, a[1:0]));
          chk({tag, "_we"}, bus_if.bus_we_o, we);
          if (we) chk({tag, "_wdata"}, bus_if.bus_wdata_o, ref_wd(t, wd));
        end
        if (req_seen == gd) begin bus_if.bus_gnt_i = 1'b1; since_gnt = 0; end
        req_seen++;
      end
      if (!we && since_gnt == rd) bus_if.bus_rvalid_i = 1'b1;
      #1;
      if (stall) stalls++;
      else begin
        done = 1'b1;
        chk({tag, "_lvalid"}, load_valid, !we);
        if (!we) begin
          last_ld = ref_load(t, a[1:0], rdata);
          chk({tag, "_ldata"}, load_data, last_ld);
        end
      end
    end
    chk({tag, "_timeout"}, done, 1);
    chk({tag, "_stalls"}, stalls, 2 + gd + (we ? 0 : rd));
    @(negedge clk);
    ena = 1'b0; bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0; #1;
    chk({tag, "_post_req"}, bus_if.bus_req_o, 0);
    chk({tag, "_post_lvalid"}, load_valid, 0);
    chk({tag, "_post_stall"}, stall, 0);
    chk({tag, "_post_hold"}, load_data, last_ld);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; wena = 1'b0; dtype = 2'd0; addr = 32'h100; wdata = 32'h0;
    bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0; bus_if.bus_rdata_i = 32'h0;
    last_ld = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus_if.bus_req_o, 0);
    chk("rst_we", bus_if.bus_we_o, 0);
    chk("rst_addr", bus_if.bus_addr_o, 0);
    chk("rst_be", bus_if.bus_be_o, 0);
    chk("rst_wdata", bus_if.bus_wdata_o, 0);
    chk("rst_ldata", load_data, 0);
    chk("rst_lvalid", load_valid, 0);
    chk("rst_mis", misalign, 0);
    ena = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    access("sw",  1'b1, 2'd0, 32'h100, 32'h1234_5678, 0, 1, 32'h0);
    access("sb",  1'b1, 2'd2, 32'h203, 32'h0000_00AB, 0, 1, 32'h0);
    access("lb",  1'b0, 2'd2, 32'h301, 32'h0,         0, 1, 32'h0000_8000);
    access("lbu", 1'b0, 2'd3, 32'h301, 32'h0,         0, 1, 32'h0000_8000);
    access("lh",  1'b0, 2'd1, 32'h402, 32'h0,         3, 2, 32'hFEDC_0000);
    access("lw_mis", 1'b0, 2'd0, 32'h105, 32'h0,      0, 1, 32'h0);

    // reset while waiting for read data
    @(negedge clk);
    ena = 1'b1; wena = 1'b0; dtype = 2'd0; addr = 32'h500;
    @(negedge clk); bus_if.bus_gnt_i = 1'b1;
    @(negedge clk); bus_if.bus_gnt_i = 1'b0; #1;
    chk("rr_resp_stall", stall, 1);
    rst_n = 1'b0; #1;
    chk("rr_req", bus_if.bus_req_o, 0);
    chk("rr_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b0;
    bus_if.bus_rvalid_i = 1'b1; bus_if.bus_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk); bus_if.bus_rvalid_i = 1'b0; #1;
    chk("rr_lvalid", load_valid, 0);
    chk("rr_ldata", load_data, 0);
    chk("rr_req2", bus_if.bus_req_o, 0);
    chk("rr_be", bus_if.bus_be_o, 0);
    chk("rr_addr", bus_if.bus_addr_o, 0);
    chk("rr_mis", misalign, 0);
    last_ld = 32'h0;

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      ra = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
      access("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra,
             $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
